// File: rtl/kronos_instr_mem.sv
// Instruction-side memory responder for the core fetch port.
// Word-addressed store that serves one fetch at a time, after a fixed number
// of wait states. Misaligned or out-of-range fetches return FILL with
// instr_err set. A backdoor port writes the store for program loading.
module kronos_instr_mem #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] FILL        = 32'h0000_0013,
  parameter int unsigned AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   instr_addr,
  input  logic          instr_req,
  output logic          instr_ack,
  output logic [31:0]   instr_data,
  output logic          instr_err,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  logic [31:0] rd_addr;
  logic [31:0] offset;
  logic [AW-1:0] idx;
  logic        fault;
  logic        enter_resp;

  // State, wait counter and latched fetch address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state: accept in IDLE, count down in WAIT, single-cycle RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle: begin
        if (instr_req) begin
          addr_d  = instr_addr;
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? StWait : StResp;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Read-side decode. With no wait states the RESP-entry edge is the accept
  // edge itself, so the live address is used before it has been latched.
  always_comb begin
    rd_addr    = (state_q == StIdle) ? instr_addr : addr_q;
    offset     = rd_addr - BASE_ADDR;
    idx        = offset[AW+1:2];
    fault      = (rd_addr[1:0] != 2'b00) || (rd_addr < BASE_ADDR) ||
                 ((offset >> 2) >= 32'(DEPTH));
    enter_resp = (state_d == StResp) && (state_q != StResp);
  end

  // Backdoor load; the store itself is never reset.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  // Response registers; reading mem here sees pre-write contents (read-first).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= 32'h0;
      err_q  <= 1'b0;
    end else begin
      if (enter_resp) data_q <= fault ? FILL : mem[idx];
      err_q <= enter_resp && fault;
    end
  end

  // Outputs decoded from state and response registers.
  always_comb begin
    instr_ack  = (state_q == StResp);
    busy       = (state_q != StIdle);
    instr_data = data_q;
    instr_err  = err_q;
  end

endmodule

// File: tb/tb_kronos_instr_mem.sv
// Directed bench for kronos_instr_mem: three instances cover zero wait states,
// three wait states, and four wait states with a non-zero base address.
module tb_kronos_instr_mem;

  logic        clk;
  logic        rst;
  logic        rst_c;
  logic [31:0] addr;
  logic        req  [3];
  logic        ack  [3];
  logic [31:0] data [3];
  logic        err  [3];
  logic        busy [3];
  logic        load_en;
  logic [3:0]  load_addr;
  logic [31:0] load_data;

  int total = 0;
  int bad   = 0;
  logic [32:0] sb [$];

  kronos_instr_mem #(
    .DEPTH(16), .BASE_ADDR(32'h0), .WAIT_STATES(0), .FILL(32'h13)
  ) u_a (
    .clk(clk), .rst(rst), .instr_addr(addr), .instr_req(req[0]), .instr_ack(ack[0]),
    .instr_data(data[0]), .instr_err(err[0]), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .busy(busy[0])
  );

  kronos_instr_mem #(
    .DEPTH(16), .BASE_ADDR(32'h0), .WAIT_STATES(3), .FILL(32'h13)
  ) u_b (
    .clk(clk), .rst(rst), .instr_addr(addr), .instr_req(req[1]), .instr_ack(ack[1]),
    .instr_data(data[1]), .instr_err(err[1]), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .busy(busy[1])
  );

  kronos_instr_mem #(
    .DEPTH(16), .BASE_ADDR(32'h1000), .WAIT_STATES(4), .FILL(32'h13)
  ) u_c (
    .clk(clk), .rst(rst_c), .instr_addr(addr), .instr_req(req[2]), .instr_ack(ack[2]),
    .instr_data(data[2]), .instr_err(err[2]), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .busy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare the current response of instance k against the scoreboard head.
  task automatic pop_cmp(input int k, input string tag);
    logic [32:0] e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=ack expected=no-pending-entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " data"}, data[k], e[31:0]);
      check({tag, " err"}, 32'(err[k]), 32'(e[32]));
    end
  endtask

  // Wait (bounded) for an ack on instance k, then score it.
  task automatic wait_ack(input int k, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (ack[k]) begin
        pop_cmp(k, tag);
        return;
      end
      tick();
    end
    total++;
    bad++;
    $error("FAIL %s observed=no-ack expected=ack-within-%0d", tag, budget);
  endtask

  task automatic do_load(input logic [3:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  // Single request on instance k; expectation pushed as the request is driven.
  task automatic fetch(input int k, input logic [31:0] a, input logic e_err,
                       input logic [31:0] e_data, input string tag);
    addr = a; req[k] = 1'b1;
    sb.push_back({e_err, e_data});
    tick();
    req[k] = 1'b0;
    wait_ack(k, 8, tag);
    tick();
    check({tag, " err clears"}, 32'(err[k]), 32'h0);
    check({tag, " data holds"}, data[k], e_data);
  endtask

  initial begin
    int seen;
    rst = 1'b1; rst_c = 1'b1; addr = 32'h0; load_en = 1'b0;
    load_addr = 4'h0; load_data = 32'h0;
    for (int k = 0; k < 3; k++) req[k] = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset ack%0d", k), 32'(ack[k]), 32'h0);
      check($sformatf("reset data%0d", k), data[k], 32'h0);
      check($sformatf("reset err%0d", k), 32'(err[k]), 32'h0);
      check($sformatf("reset busy%0d", k), 32'(busy[k]), 32'h0);
    end
    tick();
    rst = 1'b0; rst_c = 1'b0;
    tick();

    do_load(4'd0, 32'h11);
    do_load(4'd1, 32'h22);
    do_load(4'd2, 32'h33);
    do_load(4'd3, 32'h44);

    // Back-to-back stream with req held high through RESP.
    req[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 32'(4 * i);
      sb.push_back({1'b0, 32'(32'h11 * (i + 1))});
      tick();
      check($sformatf("stream ack%0d", i), 32'(ack[0]), 32'h1);
      pop_cmp(0, $sformatf("stream%0d", i));
      tick();
      check($sformatf("stream gap%0d", i), 32'(ack[0]), 32'h0);
    end
    req[0] = 1'b0;
    tick();

    // Three wait states; address changes mid-wait must be ignored.
    addr = 32'h8; req[1] = 1'b1;
    sb.push_back({1'b0, 32'h33});
    tick();
    req[1] = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      check($sformatf("ws3 busy c%0d", j), 32'(busy[1]), 32'h1);
      check($sformatf("ws3 ack c%0d", j), 32'(ack[1]), (j == 4) ? 32'h1 : 32'h0);
      if (j == 2) addr = 32'h0;
      if (j == 4) pop_cmp(1, "ws3 resp");
      tick();
    end
    check("ws3 busy after", 32'(busy[1]), 32'h0);
    check("ws3 ack after", 32'(ack[1]), 32'h0);

    // Faults and a normal fetch with a non-zero base.
    fetch(0, 32'h6, 1'b1, 32'h13, "misaligned");
    fetch(0, 32'h40, 1'b1, 32'h13, "past end");
    fetch(2, 32'h0FFC, 1'b1, 32'h13, "below base");
    fetch(2, 32'h1008, 1'b0, 32'h33, "base ok");

    // Read-first collision on the RESP-entry edge.
    do_load(4'd5, 32'hAAAA);
    addr = 32'h14; req[0] = 1'b1;
    load_en = 1'b1; load_addr = 4'd5; load_data = 32'hBBBB;
    sb.push_back({1'b0, 32'hAAAA});
    tick();
    req[0] = 1'b0; load_en = 1'b0;
    wait_ack(0, 4, "collision old");
    tick();
    fetch(0, 32'h14, 1'b0, 32'hBBBB, "collision new");

    // Reset two cycles into a four-wait-state fetch.
    addr = 32'h1004; req[2] = 1'b1;
    tick();
    req[2] = 1'b0;
    tick();
    tick();
    rst_c = 1'b1;
    #1;
    check("midrst ack", 32'(ack[2]), 32'h0);
    check("midrst busy", 32'(busy[2]), 32'h0);
    check("midrst data", data[2], 32'h0);
    tick();
    rst_c = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack[2]) seen = 1;
    end
    check("midrst no ack", 32'(seen), 32'h0);
    fetch(2, 32'h1004, 1'b0, 32'h22, "midrst refetch");

    check("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kronos_instr_mem.md
Name: kronos_instr_mem

Overview:
- Instruction-side memory responder for the core's fetch port: the target end of the instr_req/instr_ack/instr_addr/instr_data protocol driven by the fetch stage.
- Holds a word-addressed instruction store and services one fetch at a time with a programmable number of wait states.
- Has a backdoor load port for program loading and flags misaligned or out-of-range fetches.
- Sits beside the core in the SoC and integration benches, in place of a real flash or SRAM bridge.

Parameters:
- DEPTH, 1024, number of 32-bit words in the store (power of two, 2 or more); AW = $clog2(DEPTH).
- BASE_ADDR, 32'h0, byte address of word 0.
- WAIT_STATES, 0, extra cycles between request accept and ack (0 to 15).
- FILL, 32'h0000_0013, word returned on a faulting fetch (RV32 NOP).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr_addr  input  32  fetch byte address; sampled only on request accept.
- instr_req  input  1  fetch request, level.
- instr_ack  output  1  one-cycle response strobe; instr_data is valid in the same cycle.
- instr_data  output  32  fetched word.
- instr_err  output  1  high with instr_ack when the response is a faulting fetch.
- load_en  input  1  backdoor write strobe.
- load_addr  input  AW  backdoor word index.
- load_data  input  32  backdoor write data.
- busy  output  1  high while state is not IDLE.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - Outputs on reset: state=IDLE, instr_ack=0, instr_data=32'h0, instr_err=0, busy=0, wait counter=0.
  - Memory contents are not reset.
  - Reset asserted mid-transaction drops the pending fetch; no ack is issued after reset deasserts.
- State machine:
  - IDLE: instr_req=1 accepts a request. On the accept edge: latch instr_addr and load the counter with WAIT_STATES. Go to WAIT if WAIT_STATES>0, otherwise RESP.
  - WAIT: decrement the counter each cycle. When the counter reaches 1, go to RESP on the next edge. instr_req and instr_addr are ignored.
  - RESP: instr_ack=1 for exactly one cycle, then go to IDLE unconditionally. A request present during RESP is not accepted; it is accepted in the following IDLE cycle if still asserted.
- Latency: request high in IDLE cycle T gives instr_ack in cycle T+1+WAIT_STATES. Minimum spacing between acks is 2 cycles.
- Read:
  - instr_data and instr_err are registered on the edge entering RESP.
  - instr_data holds its value after ack until the next response; instr_err returns to 0 after RESP.
  - Word index = (latched_addr - BASE_ADDR) >> 2, 32-bit unsigned subtraction.
- Fault: the fetch is faulting if latched_addr[1:0] != 0, or latched_addr < BASE_ADDR, or index >= DEPTH. A faulting fetch returns instr_data=FILL, instr_err=1.
- Load port:
  - load_en writes mem[load_addr] on the clock edge, in any state.
  - A load to the word being read on the same edge that enters RESP returns the old data (read-first).
- instr_addr changing while in WAIT has no effect; the latched address is used.

Test Plan:
- WAIT_STATES=0: load mem[0..3]=0x11,0x22,0x33,0x44; hold instr_req=1 with addr 0,4,8,12 presented at each accept -> instr_ack pulses every 2 cycles with data 0x11,0x22,0x33,0x44; instr_err=0.
- WAIT_STATES=3: single request at addr 0x8 in cycle 10 -> busy=1 cycles 11-14; instr_ack=1 only in cycle 14 with data mem[2]; change instr_addr to 0x0 in cycle 12 -> response still mem[2].
- Faults: addr 0x6 -> ack with FILL 0x13, instr_err=1; addr BASE_ADDR+4*DEPTH -> FILL, err=1; with BASE_ADDR=0x1000, addr 0x0FFC -> FILL, err=1.
- Read-first collision, WAIT_STATES=0: mem[5]=0xAAAA; request 0x14 with load_en to index 5 = 0xBBBB on the RESP-entry edge -> ack data 0xAAAA; next fetch of 0x14 -> 0xBBBB.
- Reset mid-wait, WAIT_STATES=4: assert rst 2 cycles after accept -> instr_ack, busy, instr_data=0 immediately; no ack after release until a new request; memory contents intact on refetch.
- Request held high through RESP -> no accept in the RESP cycle; next ack exactly 2 cycles after the previous one (WAIT_STATES=0).
